// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter.
//   dbus_req_t / dbus_resp_t : the data-bus request and response records.
//   arb_state_t              : arbiter FSM encoding (IDLE, ADDR, DATA).
//   req_idx_t                : requester index for the default requester count.
//   idx_width()              : index width for an arbitrary requester count.
package dbus_arbiter_pkg;

  localparam int DBUS_AW = 64;
  localparam int DBUS_DW = 64;
  localparam int DBUS_SW = 8;

  typedef struct packed {
    logic               valid;
    logic [DBUS_AW-1:0] addr;
    logic [2:0]         size;
    logic [DBUS_SW-1:0] strobe;
    logic [DBUS_DW-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic               addr_ok;
    logic               data_ok;
    logic [DBUS_DW-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEFAULT = 2;

  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_idx_t;

  // Width of a requester index; at least one bit so a single requester still
  // has a legal index type.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbus_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   valid : one request-valid bit per requester
//   ptr   : index with highest priority this round
//   idx   : first valid index found scanning upward from ptr (wrapping)
//   found : at least one requester is valid
module dbus_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int          ci;
    logic [IW-1:0] c;
    ci    = 0;
    c     = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Candidate = (ptr + k) mod N, kept in int range before narrowing.
      ci = int'(ptr) + k;
      if (ci >= N) ci = ci - N;
      c = IW'(ci);
      if (!found && valid[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one data bus among NUM_REQ requesters
// (index 0 is the memory stage).
//   clk, resetn : clock, asynchronous active-low reset
//   ireqs       : per-requester requests
//   oresps      : per-requester responses (only the granted one is non-zero)
//   oreq        : request driven to the shared bus
//   iresp       : response from the shared bus
//   dbg_state   : current FSM state
//   dbg_ptr     : round-robin priority pointer
//   dbg_sel     : currently / last granted requester
//
// Handshake: a requester holds valid and its request stable until it sees
// data_ok or until it drops valid. The bus side sees oreq.valid held until
// data_ok; addr_ok marks address acceptance, data_ok marks completion (both
// may arrive in the same cycle).
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW     = idx_width(NUM_REQ)
) (
  input  logic          clk,
  input  logic          resetn,
  input  dbus_req_t     ireqs  [NUM_REQ],
  output dbus_resp_t    oresps [NUM_REQ],
  output dbus_req_t     oreq,
  input  dbus_resp_t    iresp,
  output arb_state_t    dbg_state,
  output logic [IW-1:0] dbg_ptr,
  output logic [IW-1:0] dbg_sel
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, sel_q;
  dbus_req_t     req_q;

  logic [NUM_REQ-1:0] valid_vec;
  logic [IW-1:0]      pick;
  logic               found;
  logic               sel_valid;
  logic               done;
  logic [IW-1:0]      next_ptr;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) valid_vec[i] = ireqs[i].valid;
  end

  dbus_arbiter_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_picker (
    .valid (valid_vec),
    .ptr   (ptr_q),
    .idx   (pick),
    .found (found)
  );

  // Only the valid bit of the granted requester is looked at after grant.
  assign sel_valid = ireqs[sel_q].valid;
  assign next_ptr  = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; done flags a completion or an abandon.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (found) state_d = ADDR;
      ADDR: begin
        if (iresp.addr_ok && iresp.data_ok) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (iresp.addr_ok) begin
          // addr_ok beats a same-cycle withdrawal: the transfer must drain.
          state_d = DATA;
        end else if (!sel_valid) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      DATA: begin
        if (iresp.data_ok) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping: winner index, latched request, rotating pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
      sel_q <= '0;
      req_q <= '0;
    end else begin
      if (state_q == IDLE && found) begin
        sel_q <= pick;
        req_q <= ireqs[pick];
      end
      if (done) ptr_q <= next_ptr;
    end
  end

  // Outputs: purely from state so an async reset clears them at once.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) oresps[i] = '0;
    if (state_q != IDLE) begin
      oreq       = req_q;
      oreq.valid = 1'b1;
      oresps[sel_q].addr_ok = iresp.addr_ok && (state_q == ADDR);
      // A requester that dropped valid (flushed) must not see data_ok.
      oresps[sel_q].data_ok = iresp.data_ok && sel_valid;
      oresps[sel_q].data    = iresp.data;
    end
  end

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;
  assign dbg_sel   = sel_q;

endmodule
